// File: rtl/spi_io_pkg.sv
// Shared constants and status layout for the spi_io master and spi_io_rx slave blocks.
package spi_io_pkg;

    localparam logic [31:0] SPI_IO_ADDR   = 32'h8000_0000;
    localparam logic [31:0] SPI_RX_ADDR   = 32'h8000_0008;
    localparam logic [31:0] STATUS_OFFSET = 32'h0000_0004;

    // Read-side status bit positions
    localparam int unsigned ST_NOT_EMPTY = 0;
    localparam int unsigned ST_FULL      = 1;
    localparam int unsigned ST_OVERFLOW  = 2;
    localparam int unsigned ST_FRAME_ERR = 3;

    // Write-one-to-clear positions sit one bit below their read-side counterparts
    localparam int unsigned CLR_OVERFLOW  = 1;
    localparam int unsigned CLR_FRAME_ERR = 2;

    typedef struct packed {
        logic [27:0] rsvd;
        logic        frame_err;
        logic        overflow;
        logic        full;
        logic        not_empty;
    } spi_rx_status_t;

    typedef enum logic [1:0] {
        RX_UNARMED = 2'd0,
        RX_IDLE    = 2'd1,
        RX_FRAME   = 2'd2
    } rx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead head entry.
// Latency: push visible in count/empty the cycle after; pop_dat always shows the head.
// Backpressure: push while full is dropped unless a pop happens in the same cycle.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_dat,
    input  logic                   pop,
    output logic [WIDTH-1:0]       pop_dat,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count   = wr_ptr - rd_ptr;
    assign do_pop  = pop && !empty;
    // A pop frees the slot this same cycle, so a full FIFO can still accept
    assign do_push = push && (!full || do_pop);
    assign pop_dat = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_dat;
    end

endmodule

// File: rtl/spi_io_rx.sv
// Memory-mapped SPI mode-0 slave receiver queuing inbound bytes for the core.
// Latency: byte visible in status ~4 clk after its 8th SCK rise; bus reads are combinational.
// Backpressure: MISO advertises free FIFO entries; bytes arriving while full are dropped (overflow).
module spi_io_rx #(
    parameter int unsigned FIFO_DEPTH  = 16,
    parameter logic [31:0] SPI_RX_ADDR = spi_io_pkg::SPI_RX_ADDR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] mem_bus_addr,
    input  logic [31:0] mem_bus_data,
    input  logic        mem_bus_write_en,
    input  logic        mem_bus_read_en,
    output logic [31:0] mem_bus_rx_data,
    output logic        mem_bus_rx_data_sel,
    input  logic        i_spi_sck,
    input  logic        i_spi_csn,
    input  logic        i_spi_mosi,
    output logic        o_spi_miso
);

    import spi_io_pkg::*;

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    logic sck_s1, sck_s2, sck_d;
    logic csn_s1, csn_s2, csn_d;
    logic mosi_s1, mosi_s2;

    always_ff @(posedge clk) begin
        if (rst) begin
            sck_s1  <= 1'b0; sck_s2  <= 1'b0; sck_d <= 1'b0;
            csn_s1  <= 1'b0; csn_s2  <= 1'b0; csn_d <= 1'b0;
            mosi_s1 <= 1'b0; mosi_s2 <= 1'b0;
        end else begin
            sck_s1  <= i_spi_sck;  sck_s2  <= sck_s1;  sck_d <= sck_s2;
            csn_s1  <= i_spi_csn;  csn_s2  <= csn_s1;  csn_d <= csn_s2;
            mosi_s1 <= i_spi_mosi; mosi_s2 <= mosi_s1;
        end
    end

    logic sck_rise, sck_fall, csn_fall;
    assign sck_rise = sck_s2 && !sck_d;
    assign sck_fall = !sck_s2 && sck_d;
    assign csn_fall = !csn_s2 && csn_d;

    // Synchronizers clear to 0, so after reset the block stays unarmed until csn is seen high
    rx_state_t state, state_nxt;
    logic      frame_start, frame_end, bit_rise, bit_fall;

    always_ff @(posedge clk) begin
        if (rst) state <= RX_UNARMED;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        frame_start = 1'b0;
        frame_end   = 1'b0;
        bit_rise    = 1'b0;
        bit_fall    = 1'b0;
        unique case (state)
            RX_UNARMED: if (csn_s2) state_nxt = RX_IDLE;
            RX_IDLE: begin
                if (csn_fall) begin
                    frame_start = 1'b1;
                    state_nxt   = RX_FRAME;
                end
            end
            RX_FRAME: begin
                if (csn_s2) begin
                    frame_end = 1'b1;
                    state_nxt = RX_IDLE;
                end else begin
                    bit_rise = sck_rise;
                    bit_fall = sck_fall;
                end
            end
            default: state_nxt = RX_UNARMED;
        endcase
    end

    logic [7:0]    pop_dat;
    logic          fifo_full, fifo_empty, pop;
    logic [CW-1:0] fifo_count;
    logic [8:0]    free9;
    logic [7:0]    credit;

    assign free9  = 9'(FIFO_DEPTH) - 9'(fifo_count);
    assign credit = free9[8] ? 8'hFF : free9[7:0];

    logic [2:0] bit_cnt;
    logic [7:0] rx_shift, rx_next, tx_shift, push_dat;
    logic       push_vld, miso_q;

    assign rx_next    = {rx_shift[6:0], mosi_s2};
    assign o_spi_miso = miso_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt  <= '0;
            rx_shift <= '0;
            tx_shift <= '0;
            push_dat <= '0;
            push_vld <= 1'b0;
            miso_q   <= 1'b0;
        end else begin
            push_vld <= 1'b0;
            if (frame_start) begin
                bit_cnt  <= '0;
                tx_shift <= credit;
                miso_q   <= credit[7];
            end else if (frame_end) begin
                bit_cnt  <= '0;
                miso_q   <= 1'b0;
            end else if (bit_rise) begin
                rx_shift <= rx_next;
                if (bit_cnt == 3'd7) begin
                    push_vld <= 1'b1;
                    push_dat <= rx_next;
                    bit_cnt  <= '0;
                    tx_shift <= credit;
                end else begin
                    bit_cnt  <= bit_cnt + 3'd1;
                end
            end else if (bit_fall) begin
                // Fall right after a byte boundary presents the freshly loaded MSB unshifted
                if (bit_cnt == 3'd0) begin
                    miso_q   <= tx_shift[7];
                end else begin
                    tx_shift <= {tx_shift[6:0], 1'b0};
                    miso_q   <= tx_shift[6];
                end
            end
        end
    end

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push_vld),
        .push_dat (push_dat),
        .pop      (pop),
        .pop_dat  (pop_dat),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    logic hit_data, hit_stat, clr_ovf, clr_ferr, set_ovf, set_ferr;
    logic frame_err, overflow;

    assign hit_data = (mem_bus_addr == SPI_RX_ADDR);
    assign hit_stat = (mem_bus_addr == (SPI_RX_ADDR + STATUS_OFFSET));
    assign pop      = mem_bus_read_en && hit_data && !fifo_empty;
    assign set_ovf  = push_vld && fifo_full && !pop;
    assign set_ferr = frame_end && (bit_cnt != 3'd0);
    assign clr_ovf  = mem_bus_write_en && hit_stat && mem_bus_data[CLR_OVERFLOW];
    assign clr_ferr = mem_bus_write_en && hit_stat && mem_bus_data[CLR_FRAME_ERR];

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (set_ovf)       overflow  <= 1'b1;
            else if (clr_ovf)  overflow  <= 1'b0;
            if (set_ferr)      frame_err <= 1'b1;
            else if (clr_ferr) frame_err <= 1'b0;
        end
    end

    spi_rx_status_t status;

    always_comb begin
        status           = '0;
        status.frame_err = frame_err;
        status.overflow  = overflow;
        status.full      = fifo_full;
        status.not_empty = !fifo_empty;
    end

    always_comb begin
        mem_bus_rx_data     = '0;
        mem_bus_rx_data_sel = mem_bus_read_en && (hit_data || hit_stat);
        if (mem_bus_read_en && hit_data && !fifo_empty) mem_bus_rx_data = {24'b0, pop_dat};
        else if (mem_bus_read_en && hit_stat)           mem_bus_rx_data = status;
    end

    logic unused_wdata;
    assign unused_wdata = ^{mem_bus_data[31:3], mem_bus_data[0]};

endmodule
